// File: rtl/cpu_pc_pkg.sv
// rtl/cpu_pc_pkg.sv - shared action encoding and request priority resolver for the program counter
package cpu_pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD   = 3'd0,
        PC_INC    = 3'd1,
        PC_BRANCH = 3'd2,
        PC_LOAD   = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_action_e;

    // Fixed priority: load > call > ret > branch > enable. Exactly one action wins.
    function automatic pc_action_e resolve_action(
        input logic load,
        input logic call,
        input logic ret,
        input logic branch,
        input logic enable
    );
        if (load)        return PC_LOAD;
        else if (call)   return PC_CALL;
        else if (ret)    return PC_RET;
        else if (branch) return PC_BRANCH;
        else if (enable) return PC_INC;
        else             return PC_HOLD;
    endfunction

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - parametrised LIFO holding subroutine return addresses
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears the pointer only)
//   push, push_data write push_data on top; ignored while full
//   pop             discard the top entry; ignored while empty
//   top             entry at sp-1 (meaningless while empty)
//   full, empty     decoded from the registered stack pointer
module return_stack
    import cpu_pc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [SPW-1:0]   sp;
    logic [SPW-1:0]   sp_m1;
    logic             do_push;
    logic             do_pop;

    assign full    = (sp == SPW'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign do_push = push && !full;
    // Push has precedence so a simultaneous request never becomes a swap.
    assign do_pop  = pop && !empty && !push;
    assign sp_m1   = sp - SPW'(1);
    assign top     = mem[sp_m1[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SPW'(1);
        end else if (do_pop) begin
            sp <= sp_m1;
        end
    end

    // Entry contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[sp[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - program counter with jump, relative branch and call/return stack
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   enable                         PC <= PC + 1
//   load, data_in                  PC <= data_in (also the call target)
//   branch, offset                 PC <= PC + offset (two's complement)
//   call                           push PC+1, PC <= data_in
//   ret                            PC <= popped return address
//   err_clr                        clear sticky error flags (a new error wins)
//   out                            registered PC
//   stack_full, stack_empty        return stack status
//   overflow_err, underflow_err    sticky call-while-full / ret-while-empty
module program_counter_stack
    import cpu_pc_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             branch,
    input  logic [WIDTH-1:0] offset,
    input  logic             call,
    input  logic             ret,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             overflow_err,
    output logic             underflow_err
);

    pc_action_e       action;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] stack_top;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             unf_set;

    assign action   = resolve_action(load, call, ret, branch, enable);
    assign pc_plus1 = pc + WIDTH'(1);

    return_stack #(
        .WIDTH       (WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus1),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        pc_next = pc;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (action)
            PC_LOAD:   pc_next = data_in;
            PC_CALL: begin
                if (stack_full) begin
                    ovf_set = 1'b1;
                end else begin
                    push    = 1'b1;
                    pc_next = data_in;
                end
            end
            PC_RET: begin
                if (stack_empty) begin
                    unf_set = 1'b1;
                end else begin
                    pop     = 1'b1;
                    pc_next = stack_top;
                end
            end
            // Offset is already WIDTH bits, so modular addition is the signed add.
            PC_BRANCH: pc_next = pc + offset;
            PC_INC:    pc_next = pc_plus1;
            default:   pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_VECTOR;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            pc            <= pc_next;
            overflow_err  <= (overflow_err  && !err_clr) || ovf_set;
            underflow_err <= (underflow_err && !err_clr) || unf_set;
        end
    end

    assign out = pc;

endmodule

// File: tb/tb_program_counter_stack.sv
// tb/tb_program_counter_stack.sv - directed self-checking bench for program_counter_stack
module tb_program_counter_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, load, branch, call, ret, err_clr;
    logic [7:0] data_in, offset;
    logic [7:0] out;
    logic       stack_full, stack_empty, overflow_err, underflow_err;

    int checks   = 0;
    int failures = 0;

    program_counter_stack #(
        .WIDTH        (8),
        .STACK_DEPTH  (4),
        .RESET_VECTOR (8'h00)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .load          (load),
        .data_in       (data_in),
        .branch        (branch),
        .offset        (offset),
        .call          (call),
        .ret           (ret),
        .err_clr       (err_clr),
        .out           (out),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        enable = 0; load = 0; branch = 0; call = 0; ret = 0; err_clr = 0;
        data_in = 8'h00; offset = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", out); end
        checks++;
        if ({stack_empty, stack_full, overflow_err, underflow_err} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=1000", {stack_empty, stack_full, overflow_err, underflow_err});
        end
    endtask

    task automatic test_count_and_async_reset();
        logic [7:0] exp;
        idle();
        enable = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = 8'(i);
            checks++;
            if (out !== exp) begin failures++; $display("FAIL count_%0d got=%h exp=%h", i, out, exp); end
        end
        #2;
        rst = 1;
        #1;
        checks++;
        if (out !== 8'h00) begin failures++; $display("FAIL async_reset got=%h exp=00", out); end
        idle();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_load_wrap();
        logic [7:0] exp [4];
        exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        idle();
        load = 1; data_in = 8'hFE;
        tick();
        checks++;
        if (out !== exp[0]) begin failures++; $display("FAIL load got=%h exp=%h", out, exp[0]); end
        idle();
        enable = 1;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (out !== exp[i]) begin failures++; $display("FAIL wrap_%0d got=%h exp=%h", i, out, exp[i]); end
        end
        idle();
        tick();
        checks++;
        if (out !== 8'h01) begin failures++; $display("FAIL hold got=%h exp=01", out); end
    endtask

    task automatic test_branch();
        idle();
        load = 1; data_in = 8'h10;
        tick();
        idle();
        branch = 1; offset = 8'hF0;
        tick();
        checks++;
        if (out !== 8'h00) begin failures++; $display("FAIL branch_back got=%h exp=00", out); end
        offset = 8'h05;
        tick();
        checks++;
        if (out !== 8'h05) begin failures++; $display("FAIL branch_fwd got=%h exp=05", out); end
        enable = 1; offset = 8'h02;
        tick();
        checks++;
        if (out !== 8'h07) begin failures++; $display("FAIL branch_over_inc got=%h exp=07", out); end
        idle();
    endtask

    task automatic test_nested_calls();
        idle();
        load = 1; data_in = 8'h20;
        tick();
        idle();
        call = 1; data_in = 8'h40;
        tick();
        checks++;
        if (out !== 8'h40 || stack_empty !== 1'b0) begin
            failures++; $display("FAIL call1 got=%h/%b exp=40/0", out, stack_empty);
        end
        data_in = 8'h60;
        tick();
        checks++;
        if (out !== 8'h60) begin failures++; $display("FAIL call2 got=%h exp=60", out); end
        idle();
        ret = 1;
        tick();
        checks++;
        if (out !== 8'h41) begin failures++; $display("FAIL ret1 got=%h exp=41", out); end
        tick();
        checks++;
        if (out !== 8'h21 || stack_empty !== 1'b1) begin
            failures++; $display("FAIL ret2 got=%h/%b exp=21/1", out, stack_empty);
        end
        idle();
    endtask

    task automatic test_overflow_underflow();
        logic [7:0] ret_exp [4];
        ret_exp = '{8'h33, 8'h32, 8'h31, 8'h22};
        idle();
        call = 1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'h30 + 8'(i);
            tick();
        end
        checks++;
        if (out !== 8'h33 || stack_full !== 1'b1 || overflow_err !== 1'b0) begin
            failures++; $display("FAIL fill got=%h/%b/%b exp=33/1/0", out, stack_full, overflow_err);
        end
        data_in = 8'h50;
        tick();
        checks++;
        if (out !== 8'h33 || overflow_err !== 1'b1 || stack_full !== 1'b1) begin
            failures++; $display("FAIL overflow got=%h/%b/%b exp=33/1/1", out, overflow_err, stack_full);
        end
        idle();
        ret = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out !== ret_exp[i]) begin failures++; $display("FAIL unwind_%0d got=%h exp=%h", i, out, ret_exp[i]); end
        end
        checks++;
        if (stack_empty !== 1'b1 || underflow_err !== 1'b0) begin
            failures++; $display("FAIL unwound got=%b/%b exp=1/0", stack_empty, underflow_err);
        end
        tick();
        checks++;
        if (out !== 8'h22 || underflow_err !== 1'b1 || overflow_err !== 1'b1) begin
            failures++; $display("FAIL underflow got=%h/%b/%b exp=22/1/1", out, underflow_err, overflow_err);
        end
        err_clr = 1;
        tick();
        checks++;
        if (overflow_err !== 1'b0 || underflow_err !== 1'b1) begin
            failures++; $display("FAIL clr_set_wins got=%b/%b exp=0/1", overflow_err, underflow_err);
        end
        idle();
        err_clr = 1;
        tick();
        checks++;
        if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
            failures++; $display("FAIL err_clr got=%b/%b exp=0/0", overflow_err, underflow_err);
        end
        idle();
    endtask

    task automatic test_priority();
        idle();
        load = 1; call = 1; enable = 1; data_in = 8'h80;
        tick();
        checks++;
        if (out !== 8'h80 || stack_empty !== 1'b1) begin
            failures++; $display("FAIL prio_load got=%h/%b exp=80/1", out, stack_empty);
        end
        idle();
        call = 1; ret = 1; data_in = 8'h90;
        tick();
        checks++;
        if (out !== 8'h90 || stack_empty !== 1'b0) begin
            failures++; $display("FAIL prio_call got=%h/%b exp=90/0", out, stack_empty);
        end
        idle();
        ret = 1; branch = 1; offset = 8'h10;
        tick();
        checks++;
        if (out !== 8'h81 || stack_empty !== 1'b1) begin
            failures++; $display("FAIL prio_ret got=%h/%b exp=81/1", out, stack_empty);
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        #12;
        rst = 0;
        #1;
        test_reset();
        test_count_and_async_reset();
        test_load_wrap();
        test_branch();
        test_nested_calls();
        test_overflow_underflow();
        test_priority();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised successor to the basic incrementing program counter for the 8-bit CPU.
- Adds absolute jump (load), signed relative branch, and subroutine call/return backed by a hardware LIFO return stack.
- Sits between the control unit and instruction memory address bus.
- Control unit asserts at most one action per cycle nominally; a fixed priority resolves any overlap.

Parameters:
- WIDTH, 8, PC / address width in bits
- STACK_DEPTH, 4, number of return-address entries (>=1)
- RESET_VECTOR, 0, PC value loaded on reset (WIDTH bits)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  increment PC by 1
- load  in  1  absolute jump: PC <= data_in
- data_in  in  WIDTH  jump / call target address
- branch  in  1  relative branch: PC <= PC + sign-extended offset
- offset  in  WIDTH  two's-complement branch displacement
- call  in  1  push PC+1, then PC <= data_in
- ret  in  1  pop top of stack into PC
- err_clr  in  1  synchronous clear of sticky error flags
- out  out  WIDTH  current PC (registered)
- stack_full  out  1  stack holds STACK_DEPTH entries
- stack_empty  out  1  stack holds 0 entries
- overflow_err  out  1  sticky: call attempted while full
- underflow_err  out  1  sticky: ret attempted while empty

Behaviour:
- Reset (async, any time, including mid-sequence): out=RESET_VECTOR, stack pointer=0, stack_empty=1, stack_full=0, both error flags=0. Stack entry contents are don't-care after reset.
- Action priority per cycle: load > call > ret > branch > enable. Exactly one action executes; lower-priority requests that cycle are dropped.
- No request asserted: PC holds.
- Latency: every action takes effect at the next rising edge. out reflects the new value one cycle after the request is sampled.
- enable: PC <= PC+1, modulo 2^WIDTH. 2^WIDTH-1 wraps to 0.
- branch: PC <= PC + offset, modulo 2^WIDTH; offset is WIDTH bits signed, so no extension is needed.
- load: PC <= data_in. Stack is unaffected.
- call, not full: stack[sp] <= PC+1 (wrapped); sp <= sp+1; PC <= data_in.
- call, full: no push, PC holds, overflow_err <= 1.
- ret, not empty: PC <= stack[sp-1]; sp <= sp-1.
- ret, empty: PC holds, underflow_err <= 1.
- call and ret in the same cycle: call wins, ret is ignored. No combined push/pop.
- err_clr: clears both flags at the next edge. If a new error occurs in the same cycle, set wins.
- Stack status derivation: sp is a counter of width $clog2(STACK_DEPTH+1). stack_full = (sp==STACK_DEPTH); stack_empty = (sp==0). Both are decoded from the registered sp, with no combinational path from inputs.
- out is driven directly from the PC register, with no combinational path from inputs.

Decomposition:
- Shared package cpu_pc_pkg holds:
  - action encoding enum: PC_HOLD, PC_INC, PC_BRANCH, PC_LOAD, PC_CALL, PC_RET
  - the priority-resolve function mapping request bits to the enum
- One sub-module, return_stack: parametrised LIFO (WIDTH, STACK_DEPTH).
  - inputs: push, pop, push_data
  - outputs: top, full, empty
  - same clk/rst
  - push while full and pop while empty are ignored internally
- The top level owns the PC register, the action mux, and the error flags.

Test Plan (WIDTH=8, STACK_DEPTH=4, RESET_VECTOR=0):
- Reset then enable high for 3 cycles -> out 0,1,2,3; assert rst mid-count -> out=0 immediately, without waiting for a clock edge.
- load data_in=0xFE, then enable x3 -> out 0xFE, 0xFF, 0x00, 0x01 (wrap).
- out=0x10; branch offset=0xF0 (-16) -> 0x00; then branch offset=0x05 -> 0x05.
- Nested calls, from out=0x20:
  - call 0x40 -> out=0x40
  - call 0x60 -> out=0x60
  - ret -> out=0x41
  - ret -> out=0x21, stack_empty=1
- Overflow and underflow:
  - 4 calls -> stack_full=1
  - 5th call -> PC holds, overflow_err=1
  - 4 rets, then one more ret -> PC holds, underflow_err=1
  - err_clr -> both flags 0
- Priority: load=1, call=1, enable=1, data_in=0x80 -> out=0x80, stack_empty still 1. Next, call=1 and ret=1 with data_in=0x90 -> out=0x90, one entry (0x81) pushed.
